// File: rtl/btn_pkg.sv
// Shared types and constants for the button event controller.
// Optional auto-repeat logic is enabled with `define BTN_AUTOREPEAT_EN.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HOLD_WAIT = 2'd1,
      ST_REPEAT    = 2'd2
   } btn_fsm_e;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, press pulse and,
// with `define BTN_AUTOREPEAT_EN, the hold/auto-repeat FSM.
module btn_channel
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 65535,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic pulse,
   output logic pulse_rep
);

   logic        sync1_q, sync2_q;
   logic        level_q, level_d;
   logic        press_q, press_d;
   logic [31:0] db_cnt_q, db_cnt_d;

   // Counter only advances while the synchronized input disagrees with the level
   always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (sync2_q != level_q) begin
         if (db_cnt_q == 32'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 32'd1;
         end
      end
      press_d = level_d & ~level_q;
   end

`ifdef BTN_AUTOREPEAT_EN
   btn_fsm_e    st_q, st_d;
   logic [31:0] rp_cnt_q, rp_cnt_d;
   logic        rep_q, rep_d;

   always_comb begin
      st_d     = st_q;
      rp_cnt_d = rp_cnt_q;
      rep_d    = 1'b0;
      if (!level_d) begin
         st_d     = ST_IDLE;
         rp_cnt_d = '0;
      end else begin
         case (st_q)
            ST_IDLE: begin
               if (press_d) begin
                  st_d     = ST_HOLD_WAIT;
                  rp_cnt_d = '0;
               end
            end
            ST_HOLD_WAIT: begin
               if (rp_cnt_q == 32'(REPEAT_DELAY - 1)) begin
                  rep_d    = 1'b1;
                  rp_cnt_d = '0;
                  st_d     = ST_REPEAT;
               end else begin
                  rp_cnt_d = rp_cnt_q + 32'd1;
               end
            end
            ST_REPEAT: begin
               if (rp_cnt_q == 32'(REPEAT_PERIOD - 1)) begin
                  rep_d    = 1'b1;
                  rp_cnt_d = '0;
               end else begin
                  rp_cnt_d = rp_cnt_q + 32'd1;
               end
            end
            default: begin
               st_d     = ST_IDLE;
               rp_cnt_d = '0;
            end
         endcase
      end
   end

   assign pulse     = press_q | rep_q;
   assign pulse_rep = rep_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
   assign pulse      = press_q;
   assign pulse_rep  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         level_q  <= 1'b0;
         press_q  <= 1'b0;
         db_cnt_q <= '0;
`ifdef BTN_AUTOREPEAT_EN
         st_q     <= ST_IDLE;
         rp_cnt_q <= '0;
         rep_q    <= 1'b0;
`endif
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         level_q  <= level_d;
         press_q  <= press_d;
         db_cnt_q <= db_cnt_d;
`ifdef BTN_AUTOREPEAT_EN
         st_q     <= st_d;
         rp_cnt_q <= rp_cnt_d;
         rep_q    <= rep_d;
`endif
      end
   end

   assign level = level_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Multi-button debouncer with per-channel pending bits, priority arbitration
// and a 4-entry show-ahead event FIFO. Auto-repeat via `define BTN_AUTOREPEAT_EN.
module button_event_ctrl
   import btn_pkg::*;
#(
   parameter int unsigned NUM_BTN         = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 65535,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_BTN-1:0]         button,
   output logic [NUM_BTN-1:0]         button_state,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [$clog2(NUM_BTN)-1:0] evt_id,
   output logic                       evt_repeat,
   output logic                       overflow
);

   localparam int unsigned IDW = $clog2(NUM_BTN);
   localparam int unsigned EW  = IDW + 1;

   logic [NUM_BTN-1:0] ch_pulse, ch_rep;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .btn_raw   (button[gi]),
         .level     (button_state[gi]),
         .pulse     (ch_pulse[gi]),
         .pulse_rep (ch_rep[gi])
      );
   end

   logic [NUM_BTN-1:0]    pend_q, pend_d, pend_rep_q, pend_rep_d;
   logic                  ovf_q, ovf_d;
   logic [EW-1:0]         mem_q [FIFO_DEPTH];
   logic [EW-1:0]         mem_d [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [FIFO_PTR_W:0]   cnt_q, cnt_d;
   logic                  full, push, pop;
   logic                  grant_vld, grant_rep;
   logic [IDW-1:0]        grant_id;
   logic [EW-1:0]         head;

   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      grant_rep = 1'b0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         if (!grant_vld && pend_q[i]) begin
            grant_vld = 1'b1;
            grant_id  = IDW'(i);
            grant_rep = pend_rep_q[i];
         end
      end
   end

   assign full      = (cnt_q == (FIFO_PTR_W + 1)'(FIFO_DEPTH));
   assign push      = grant_vld & ~full;
   assign evt_valid = (cnt_q != '0);
   assign pop       = evt_valid & evt_ready;

   // A pulse is dropped only if the pending bit stays set after this cycle's push
   always_comb begin
      pend_d     = pend_q;
      pend_rep_d = pend_rep_q;
      ovf_d      = ovf_q;
      if (push) begin
         pend_d[grant_id] = 1'b0;
      end
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         if (ch_pulse[i]) begin
            if (pend_d[i]) begin
               ovf_d = 1'b1;
            end else begin
               pend_d[i]     = 1'b1;
               pend_rep_d[i] = ch_rep[i];
            end
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[wr_q] = {grant_id, grant_rep};
         wr_d        = wr_q + FIFO_PTR_W'(1);
      end
      if (pop) begin
         rd_d = rd_q + FIFO_PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (FIFO_PTR_W + 1)'(1);
         2'b01:   cnt_d = cnt_q - (FIFO_PTR_W + 1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q     <= '0;
         pend_rep_q <= '0;
         ovf_q      <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         pend_q     <= pend_d;
         pend_rep_q <= pend_rep_d;
         ovf_q      <= ovf_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
      end
   end

   assign head     = mem_q[rd_q];
   assign evt_id   = head[EW-1:1];
   assign overflow = ovf_q;

`ifdef BTN_AUTOREPEAT_EN
   assign evt_repeat = head[0];
`else
   logic unused_rep;
   assign unused_rep = head[0];
   assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed self-checking bench for button_event_ctrl (D=8, delay=20, period=10).
// Repeat expectations follow `define BTN_AUTOREPEAT_EN.
module tb_button_event_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] button;
   logic [3:0] button_state;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_id;
   logic       evt_repeat;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int log_id[$];
   int log_rep[$];
   int log_cyc[$];

   button_event_ctrl #(
      .NUM_BTN         (4),
      .DEBOUNCE_CYCLES (8),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (10)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .button       (button),
      .button_state (button_state),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_id       (evt_id),
      .evt_repeat   (evt_repeat),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted event; values are stable at the falling edge
   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready) begin
         log_id.push_back(int'(evt_id));
         log_rep.push_back(int'(evt_repeat));
         log_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int lid(input int k);
      return (k < log_id.size()) ? log_id[k] : -1;
   endfunction

   function automatic int lrep(input int k);
      return (k < log_rep.size()) ? log_rep[k] : -1;
   endfunction

   function automatic int lcyc(input int k);
      return (k < log_cyc.size()) ? log_cyc[k] : -1000;
   endfunction

   task automatic clear_log();
      log_id.delete();
      log_rep.delete();
      log_cyc.delete();
   endtask

   initial begin
      rst       = 1'b1;
      button    = 4'b0000;
      evt_ready = 1'b0;
      tick(3);
      check_eq("rst_state", int'(button_state), 0);
      check_eq("rst_valid", int'(evt_valid), 0);
      check_eq("rst_ovf", int'(overflow), 0);
      rst = 1'b0;
      evt_ready = 1'b1;
      tick(2);

      // Bounce on channel 0, then a clean rising step
      for (int k = 0; k < 10; k++) begin
         button[0] = (k % 2 == 0);
         tick(3);
      end
      check_eq("bounce_no_flip", int'(button_state), 0);
      button[0] = 1'b1;
      tick(9);
      check_eq("deb_edge9", int'(button_state[0]), 0);
      tick(1);
      check_eq("deb_edge10", int'(button_state[0]), 1);
      tick(1);
      check_eq("lat_pend_valid", int'(evt_valid), 0);
      tick(1);
      check_eq("lat_valid", int'(evt_valid), 1);
      check_eq("lat_id", int'(evt_id), 0);
      check_eq("lat_rep", int'(evt_repeat), 0);
      tick(1);
      button[0] = 1'b0;
      tick(20);
      check_eq("bounce_evt_cnt", log_id.size(), 1);
      check_eq("bounce_evt_id", lid(0), 0);
      check_eq("bounce_evt_rep", lrep(0), 0);
      check_eq("release_state", int'(button_state), 0);

      // Simultaneous press on channels 1 and 2
      clear_log();
      button = 4'b0110;
      tick(10);
      check_eq("dual_state", int'(button_state), 6);
      tick(2);
      check_eq("dual_v1", int'(evt_valid), 1);
      check_eq("dual_id1", int'(evt_id), 1);
      tick(1);
      check_eq("dual_v2", int'(evt_valid), 1);
      check_eq("dual_id2", int'(evt_id), 2);
      button = 4'b0000;
      tick(20);
      check_eq("dual_cnt", log_id.size(), 2);
      check_eq("dual_log0", lid(0), 1);
      check_eq("dual_log1", lid(1), 2);
      check_eq("dual_gap", lcyc(1) - lcyc(0), 1);

      // Long hold on channel 3
      clear_log();
      button[3] = 1'b1;
      tick(55);
      check_eq("hold_state", int'(button_state[3]), 1);
      button[3] = 1'b0;
      tick(40);
      check_eq("hold_press_id", lid(0), 3);
      check_eq("hold_press_rep", lrep(0), 0);
`ifdef BTN_AUTOREPEAT_EN
      check_eq("hold_cnt", log_id.size(), 5);
      for (int k = 1; k < 5; k++) begin
         check_eq($sformatf("rep%0d_id", k), lid(k), 3);
         check_eq($sformatf("rep%0d_rep", k), lrep(k), 1);
         check_eq($sformatf("rep%0d_off", k), lcyc(k) - lcyc(0), 10 + 10 * k);
      end
`else
      check_eq("hold_cnt", log_id.size(), 1);
`endif

      // Fill the FIFO with consumer stalled, then overflow on channel 0
      clear_log();
      evt_ready = 1'b0;
      button = 4'b1111;
      tick(12);
      button = 4'b0000;
      tick(4);
      check_eq("full_valid", int'(evt_valid), 1);
      check_eq("full_head", int'(evt_id), 0);
      tick(9);
      button[0] = 1'b1;
      tick(12);
      button[0] = 1'b0;
      tick(11);
      button[0] = 1'b1;
      tick(10);
      check_eq("ovf_before", int'(overflow), 0);
      tick(2);
      check_eq("ovf_set", int'(overflow), 1);
      button[0] = 1'b0;
      tick(15);
      check_eq("ovf_sticky", int'(overflow), 1);
      check_eq("stall_valid", int'(evt_valid), 1);
      check_eq("stall_id", int'(evt_id), 0);
      check_eq("stall_rep", int'(evt_repeat), 0);
      evt_ready = 1'b1;
      tick(20);
      check_eq("drain_cnt", log_id.size(), 5);
      check_eq("drain_id0", lid(0), 0);
      check_eq("drain_id1", lid(1), 1);
      check_eq("drain_id2", lid(2), 2);
      check_eq("drain_id3", lid(3), 3);
      check_eq("drain_id4", lid(4), 0);
      check_eq("drain_empty", int'(evt_valid), 0);

      // Reset while channel 0 is held in auto-repeat
      clear_log();
      button[0] = 1'b1;
      tick(33);
      rst = 1'b1;
      tick(1);
      check_eq("mrst_state", int'(button_state), 0);
      check_eq("mrst_valid", int'(evt_valid), 0);
      check_eq("mrst_ovf", int'(overflow), 0);
      check_eq("mrst_rep", int'(evt_repeat), 0);
      rst = 1'b0;
      tick(11);
      check_eq("mrst_pre_valid", int'(evt_valid), 0);
      tick(1);
      check_eq("mrst_valid_again", int'(evt_valid), 1);
      check_eq("mrst_id", int'(evt_id), 0);
      check_eq("mrst_press", int'(evt_repeat), 0);
      check_eq("mrst_level", int'(button_state[0]), 1);
      button[0] = 1'b0;
      tick(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
